// File: rtl/risac_ifetch_fifo.sv
// Instruction prefetch FIFO fed by an Avalon-MM read master, with redirect/discard handling.
// Optional macro RISAC_IFETCH_BYPASS_EN forwards accepted read data straight to the head when the FIFO is empty.
module risac_ifetch_fifo #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        fetch_ready,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_data,
    output logic [31:0] avIB_address,
    output logic        avIB_read,
    input  logic [31:0] avIB_readdata,
    input  logic        avIB_waitrequest
);
    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL    = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic {RUN, DISCARD} state_t;

    state_t           state, state_next;
    logic [31:0]      pc_q, pc_next;
    logic [31:0]      held_pc, held_pc_next;
    logic [31:0]      aligned_pc;
    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [31:0]      mem_pc   [DEPTH];
    logic [31:0]      mem_data [DEPTH];
    logic             accept, push, pop, flush, bypass_hit;

    // Handshake: a read is accepted in the cycle avIB_read=1 and avIB_waitrequest=0;
    // readdata is valid in that same cycle. The address is fetch PC in both states,
    // and fetch PC only moves on acceptance, so a stalled read stays stable.
    assign avIB_read    = !rst && ((state == DISCARD) || (count != FULL));
    assign avIB_address = pc_q;
    assign accept       = avIB_read && !avIB_waitrequest;
    assign aligned_pc   = redirect_pc & ~32'h3;

    always_comb begin
        state_next   = state;
        pc_next      = pc_q;
        held_pc_next = held_pc;
        flush        = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        bypass_hit   = 1'b0;
        case (state)
            RUN: begin
                if (redirect) begin
                    flush = 1'b1;
                    // A stalled read cannot be withdrawn; finish it in DISCARD and drop it.
                    if (avIB_read && avIB_waitrequest) begin
                        held_pc_next = aligned_pc;
                        state_next   = DISCARD;
                    end else begin
                        pc_next = aligned_pc;
                    end
                end else begin
`ifdef RISAC_IFETCH_BYPASS_EN
                    bypass_hit = accept && (count == '0);
`endif
                    pop = (count != '0) && fetch_ready;
                    if (accept) begin
                        pc_next = pc_q + 32'd4;
                        push    = !(bypass_hit && fetch_ready);
                    end
                end
            end
            DISCARD: begin
                if (redirect) begin
                    held_pc_next = aligned_pc;
                end
                if (accept) begin
                    pc_next    = redirect ? aligned_pc : held_pc;
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    assign fetch_valid = (count != '0) || bypass_hit;
    assign fetch_pc    = bypass_hit ? pc_q : mem_pc[rd_ptr];
    assign fetch_data  = bypass_hit ? avIB_readdata : mem_data[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            pc_q    <= RESET_PC;
            held_pc <= RESET_PC;
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc[i]   <= '0;
                mem_data[i] <= '0;
            end
        end else begin
            state   <= state_next;
            pc_q    <= pc_next;
            held_pc <= held_pc_next;
            if (flush) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    mem_pc[wr_ptr]   <= pc_q;
                    mem_data[wr_ptr] <= avIB_readdata;
                    wr_ptr           <= wr_ptr + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                case ({push, pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: doc/risac_ifetch_fifo.md
RISAC_IFETCH_FIFO -- requirements
Module: risac_ifetch_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4: FIFO entries, power of 2, 2..16.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port redirect, input, 1: core requests fetch from a new PC.
REQ-006 SHALL have port redirect_pc, input, 32: new fetch PC, valid with redirect.
REQ-007 SHALL have port fetch_ready, input, 1: core consumes the head entry.
REQ-008 SHALL have port fetch_valid, output, 1: head entry valid.
REQ-009 SHALL have port fetch_pc, output, 32: address of head instruction.
REQ-010 SHALL have port fetch_data, output, 32: head instruction word.
REQ-011 SHALL have port avIB_address, output, 32: Avalon-MM instruction read address.
REQ-012 SHALL have port avIB_read, output, 1: Avalon read request.
REQ-013 SHALL have port avIB_readdata, input, 32: read data, valid when avIB_read=1 and avIB_waitrequest=0.
REQ-014 SHALL have port avIB_waitrequest, input, 1: slave stall.

Function
REQ-015 SHALL accept an Avalon read in any cycle with avIB_read=1 and avIB_waitrequest=0; data is captured that same cycle (no readdatavalid).
REQ-016 SHALL keep avIB_address and avIB_read stable while avIB_read=1 and avIB_waitrequest=1.
REQ-017 SHALL have FSM states RUN and DISCARD.
REQ-018 In RUN, SHALL drive avIB_read=1 when count < DEPTH at cycle start, with avIB_address = fetch PC.
REQ-019 In RUN, on acceptance SHALL push {PC, readdata} and increment the fetch PC by 4 (wraps modulo 2^32).
REQ-020 SHALL pop the head when fetch_valid=1 and fetch_ready=1; a push and a pop in the same cycle leave count unchanged.
REQ-021 With count=DEPTH, SHALL drive avIB_read=0; a pop that cycle does not allow a read until the next cycle.
REQ-022 On redirect with no held read (avIB_read=0, or read accepted this cycle), SHALL flush the FIFO, discard any data accepted this cycle, load the fetch PC with {redirect_pc[31:2],2'b00}, and stay in RUN.
REQ-023 On redirect while a read is held (avIB_read=1, avIB_waitrequest=1), SHALL flush the FIFO, latch the aligned redirect_pc, and enter DISCARD.
REQ-024 In DISCARD, SHALL hold the read until accepted, drop its data, load the latched PC, and return to RUN.
REQ-025 A later redirect in DISCARD SHALL overwrite the latched PC.
REQ-026 On simultaneous redirect and pop, redirect wins; fetch_valid SHALL be 0 the next cycle.
REQ-027 fetch_pc and fetch_data SHALL be don't-care when fetch_valid=0.
REQ-028 Minimum latency from acceptance to fetch_valid=1 into an empty FIFO SHALL be 1 cycle; see REQ-032.

Reset
REQ-029 On rst=1, SHALL asynchronously clear count and pointers, set state RUN, and set the fetch PC to RESET_PC.
REQ-030 During reset, SHALL drive fetch_valid=0, avIB_read=0, and avIB_address=RESET_PC; fetch_pc and fetch_data reset to 0.
REQ-031 If reset asserts mid-transfer, SHALL abandon the held read; the first read after reset release is to RESET_PC.

Configuration
REQ-032 With macro RISAC_IFETCH_BYPASS_EN defined, when the FIFO is empty and no redirect is present, accepted readdata SHALL appear combinationally on fetch_data/fetch_pc with fetch_valid=1 in the same cycle; with fetch_ready=1 it is consumed without a push.
REQ-033 Without RISAC_IFETCH_BYPASS_EN, all outputs SHALL come from FIFO registers only, with 1-cycle minimum latency.

Verification
REQ-034 Reset release, waitrequest=0, fetch_ready=1: SHALL read addresses 0,4,8,...; fetch_pc sequence 0,4,8 with matching data.
REQ-035 fetch_ready=0, DEPTH=4: after 4 accepts, SHALL drop avIB_read; count=4 holds; one pop SHALL trigger one read at 0x10.
REQ-036 waitrequest=1 for 5 cycles at 0x8: SHALL hold avIB_address=0x8 and avIB_read=1 throughout.
REQ-037 Redirect to 0x1003 during a held read at 0xC: SHALL drop 0xC data, then read 0x1000, and output fetch_pc=0x1000 first.
REQ-038 Fetch PC 0xFFFF_FFFC accepted: SHALL issue the next read to 0x0000_0000.
REQ-039 Bypass build, empty FIFO, accept at 0x20 with fetch_ready=1: SHALL give fetch_valid=1, fetch_pc=0x20 in the same cycle, count stays 0; non-bypass build SHALL show it one cycle later.
